mem_lsu: RTL and testbench
==========================

// Module: mem_lsu
// PURPOSE
//  Memory-stage load/store unit. Consumes the execute stage's memory request (aluop, effective address, store data)
//  via ex_mem, drives a req/gnt/rvalid data bus, stalls the pipeline until the access completes, and returns
//  sign/zero-extended load data (or passes the ALU result through) to mem_wb. Sits between ex_mem and mem_wb.
// PARAMETERS
//  (none; widths come from bitty_defs.v: `AluOpBus, `RegAddrBus, `RegBus, `DataAddrBus)
// PORTS
//  clk            in   1            core clock; all state on rising edge
//  rst            in   1            asynchronous, active-high reset
//  aluop_i        in   `AluOpBus    op from ex_mem (`EXE_LB/LH/LW/LBU/LHU/SB/SH/SW = memory ops)
//  mem_addr_i     in   32           effective byte address from ex
//  reg2_i         in   32           store data (rs2)
//  wd_i/wreg_i    in   `RegAddrBus/1 destination reg / write enable from ex_mem
//  wdata_i        in   32           non-memory result, passed through
//  wd_o/wreg_o    out  `RegAddrBus/1 to mem_wb
//  wdata_o        out  32           load result or wdata_i
//  stallreq_o     out  1            to ctrl; high freezes pc..ex_mem
//  dbus_req_o     out  1            bus request, held until dbus_gnt_i
//  dbus_we_o      out  1            1 = store
//  dbus_addr_o    out  32           {mem_addr_i[31:2],2'b00}
//  dbus_be_o      out  4            byte lanes
//  dbus_wdata_o   out  32           lane-replicated store data
//  dbus_gnt_i     in   1            request accepted this cycle
//  dbus_rvalid_i  in   1            load data valid; never in the gnt cycle
//  dbus_rdata_i   in   32           load word
//  misalign_o     out  1            misaligned access flag (tied 0 without LSU_MISALIGN_TRAP_EN)
// BEHAVIOUR
//  - States: IDLE, REQ, WAIT_R, DONE. Reset: state=IDLE, load capture reg=0; all outputs then 0/combinational of 0 state.
//  - memop = aluop_i is a load/store. dbus_req_o = (IDLE & memop) | REQ. stallreq_o = memop & state!=DONE.
//  - IDLE: memop & gnt -> store: DONE, load: WAIT_R; memop & !gnt -> REQ; else stay.
//  - REQ: hold req/addr/be/wdata stable; on gnt -> DONE (store) or WAIT_R (load).
//  - WAIT_R: on rvalid capture extended data -> DONE. DONE: stall low for exactly one cycle -> IDLE.
//  - Min latency: store 2 cycles (1 stall), load 3 cycles (2 stall). Bus wait states add 1 cycle each.
//  - Lanes: SB be=4'b0001<<a[1:0], wdata={4{rs2[7:0]}}; SH be=4'b0011<<{a[1],1'b0}, wdata={2{rs2[15:0]}}; SW be=4'hF.
//    Loads: be as for same width; byte/half selected by a[1:0]/a[1]; LB/LH sign-extend, LBU/LHU zero-extend.
//  - wdata_o = load op ? capture reg : wdata_i; wd_o=wd_i; wreg_o=wreg_i (stores: wreg_i=0 from decode).
//  - rvalid outside WAIT_R ignored; gnt outside IDLE(memop)/REQ ignored.
//  - Async reset mid-access: immediate IDLE, req drops; late gnt/rvalid after reset ignored.
//  - Non-memory ops: never request, never stall, zero added latency.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: LH/LHU/SH with a[0]=1 or LW/SW with a[1:0]!=0 issue no bus request; IDLE->DONE,
//    1 stall cycle; in DONE misalign_o=1, wreg_o=0, wdata_o=0.
//  Undefined: misalign_o=0; misaligned ops proceed with ignored low bits (half uses a[1], word uses a[31:2]).
// TESTING
//  1 SW 0xDEADBEEF @0x100, gnt same cycle -> be=F, addr=0x100, we=1, stall 1 cycle, DONE next cycle.
//  2 LB @0x103, rdata=0x80FF_FF7F, gnt cyc0, rvalid cyc2 -> wdata_o=0xFFFFFF80, stall 3 cycles.
//  3 LHU @0x102, rdata=0x8001_1234 -> wdata_o=0x00008001; SH 0xABCD @0x102 -> be=4'b1100, wdata=0xABCDABCD.
//  4 SB @0x201 with gnt low 3 cycles -> req/addr/be stable all 4 cycles, single transfer on gnt.
//  5 rst pulse while in WAIT_R, then rvalid -> state IDLE, stallreq_o=0, rvalid ignored, wdata_o unchanged.
//  6 LW @0x102: with LSU_MISALIGN_TRAP_EN -> no req, misalign_o=1, wreg_o=0; without -> addr=0x100, be=F.

Source files
------------

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: drives a req/gnt/rvalid data bus, stalls the pipeline while an access is open,
// and returns extended load data. Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
`ifndef AluOpBus
`define AluOpBus 7:0
`endif
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif
`ifndef RegBus
`define RegBus 31:0
`endif
`ifndef DataAddrBus
`define DataAddrBus 31:0
`endif
`ifndef EXE_LB_OP
`define EXE_LB_OP  8'b11100000
`define EXE_LH_OP  8'b11100001
`define EXE_LW_OP  8'b11100011
`define EXE_LBU_OP 8'b11100100
`define EXE_LHU_OP 8'b11100101
`define EXE_SB_OP  8'b11101000
`define EXE_SH_OP  8'b11101001
`define EXE_SW_OP  8'b11101011
`endif

module mem_lsu (
  input  logic               clk,
  input  logic               rst,
  input  logic [`AluOpBus]   aluop_i,
  input  logic [`DataAddrBus] mem_addr_i,
  input  logic [`RegBus]     reg2_i,
  input  logic [`RegAddrBus] wd_i,
  input  logic               wreg_i,
  input  logic [`RegBus]     wdata_i,
  output logic [`RegAddrBus] wd_o,
  output logic               wreg_o,
  output logic [`RegBus]     wdata_o,
  output logic               stallreq_o,
  output logic               dbus_req_o,
  output logic               dbus_we_o,
  output logic [31:0]        dbus_addr_o,
  output logic [3:0]         dbus_be_o,
  output logic [31:0]        dbus_wdata_o,
  input  logic               dbus_gnt_i,
  input  logic               dbus_rvalid_i,
  input  logic [31:0]        dbus_rdata_i,
  output logic               misalign_o,
  output logic [1:0]         dbg_state_o
);

  // Bus handshake: a request is presented while dbus_req_o is high and transfers in the cycle dbus_gnt_i is
  // also high; load data arrives later as a single dbus_rvalid_i pulse, only honoured in S_WAIT_R.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_load_data;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_memop;
  logic        w_signed;
  logic [1:0]  w_size;
  logic [1:0]  w_lane;
  logic [3:0]  w_be;
  logic [31:0] w_st_data;
  logic [31:0] w_shifted;
  logic [31:0] w_load_ext;
  logic        w_trap;
  logic        w_trap_done;

  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_signed   = 1'b0;
    w_size     = 2'd0;
    case (aluop_i)
      `EXE_LB_OP:  begin w_is_load  = 1'b1; w_signed = 1'b1; w_size = 2'd0; end
      `EXE_LBU_OP: begin w_is_load  = 1'b1; w_size = 2'd0; end
      `EXE_LH_OP:  begin w_is_load  = 1'b1; w_signed = 1'b1; w_size = 2'd1; end
      `EXE_LHU_OP: begin w_is_load  = 1'b1; w_size = 2'd1; end
      `EXE_LW_OP:  begin w_is_load  = 1'b1; w_size = 2'd2; end
      `EXE_SB_OP:  begin w_is_store = 1'b1; w_size = 2'd0; end
      `EXE_SH_OP:  begin w_is_store = 1'b1; w_size = 2'd1; end
      `EXE_SW_OP:  begin w_is_store = 1'b1; w_size = 2'd2; end
      default:     begin w_is_load  = 1'b0; end
    endcase
  end

  assign w_memop = w_is_load | w_is_store;

  always_comb begin
    w_lane    = 2'd0;
    w_be      = 4'hF;
    w_st_data = reg2_i;
    case (w_size)
      2'd0: begin
        w_lane    = mem_addr_i[1:0];
        w_be      = 4'b0001 << w_lane;
        w_st_data = {4{reg2_i[7:0]}};
      end
      2'd1: begin
        w_lane    = {mem_addr_i[1], 1'b0};
        w_be      = 4'b0011 << w_lane;
        w_st_data = {2{reg2_i[15:0]}};
      end
      default: begin
        w_lane    = 2'd0;
        w_be      = 4'hF;
        w_st_data = reg2_i;
      end
    endcase
  end

  assign w_shifted = dbus_rdata_i >> {w_lane, 3'b000};

  always_comb begin
    w_load_ext = dbus_rdata_i;
    case (w_size)
      2'd0:    w_load_ext = {{24{w_signed & w_shifted[7]}}, w_shifted[7:0]};
      2'd1:    w_load_ext = {{16{w_signed & w_shifted[15]}}, w_shifted[15:0]};
      default: w_load_ext = dbus_rdata_i;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_misalign;
  assign w_trap = w_memop & (((w_size == 2'd1) & mem_addr_i[0]) |
                             ((w_size == 2'd2) & (mem_addr_i[1:0] != 2'b00)));
  assign w_trap_done = r_misalign & (r_state == S_DONE);
`else
  assign w_trap      = 1'b0;
  assign w_trap_done = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_load_data <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_misalign  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_memop) begin
            if (w_trap) begin
              r_state <= S_DONE;
`ifdef LSU_MISALIGN_TRAP_EN
              r_misalign <= 1'b1;
`endif
            end else if (dbus_gnt_i) begin
              r_state <= w_is_store ? S_DONE : S_WAIT_R;
            end else begin
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (dbus_gnt_i) r_state <= w_is_store ? S_DONE : S_WAIT_R;
        end
        S_WAIT_R: begin
          if (dbus_rvalid_i) begin
            r_load_data <= w_load_ext;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
          r_misalign <= 1'b0;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dbus_req_o   = (((r_state == S_IDLE) & w_memop) | (r_state == S_REQ)) & ~w_trap;
  assign stallreq_o   = w_memop & (r_state != S_DONE);
  assign dbus_we_o    = dbus_req_o & w_is_store;
  assign dbus_addr_o  = dbus_req_o ? {mem_addr_i[31:2], 2'b00} : 32'd0;
  assign dbus_be_o    = dbus_req_o ? w_be : 4'd0;
  assign dbus_wdata_o = dbus_we_o ? w_st_data : 32'd0;

  assign wd_o        = wd_i;
  assign wreg_o      = wreg_i & ~w_trap_done;
  assign wdata_o     = w_trap_done ? 32'd0 : (w_is_load ? r_load_data : wdata_i);
  assign misalign_o  = w_trap_done;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized bench for mem_lsu against a transaction-level reference model (lanes, extension, stall count).
module tb_mem_lsu;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADD = 8'h20;
  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i, wdata_i;
  logic [4:0]  wd_i, wd_o;
  logic        wreg_i, wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o, dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o, dbus_rdata_i;
  logic [3:0]  dbus_be_o;
  logic        dbus_gnt_i, dbus_rvalid_i, misalign_o;
  logic [1:0]  dbg_state_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  mem_lsu dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .stallreq_o(stallreq_o), .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o),
    .dbus_addr_o(dbus_addr_o), .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i),
    .misalign_o(misalign_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic int op_size(input logic [7:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic bit is_load(input logic [7:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) || (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic bit is_signed_ld(input logic [7:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

  function automatic bit misaligned(input logic [7:0] op, input logic [31:0] a);
    int sz = op_size(op);
    return (sz == 2 && (a % 2) != 0) || (sz == 4 && (a % 4) != 0);
  endfunction

  function automatic int lane_of(input logic [7:0] op, input logic [31:0] a);
    int sz = op_size(op);
    if (sz == 1) return int'(a % 4);
    if (sz == 2) return int'(((a % 4) / 2) * 2);
    return 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [7:0] op, input logic [31:0] a);
    int m = ((1 << op_size(op)) - 1) << lane_of(op, a);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [7:0] op, input logic [31:0] d);
    int sz = op_size(op);
    if (sz == 1) return (d % 256) * 32'h01010101;
    if (sz == 2) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] a,
                                             input logic [31:0] word);
    logic [31:0] v = word >> (8 * lane_of(op, a));
    int sz = op_size(op);
    if (sz == 1) begin
      v = v % 256;
      if (is_signed_ld(op) && v >= 128) v = v + 32'hFFFFFF00;
    end else if (sz == 2) begin
      v = v % 65536;
      if (is_signed_ld(op) && v >= 32768) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  // driver: presents one ex_mem op, grant after g cycles, rvalid r cycles after grant
  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [31:0] wdat, input logic [4:0] wd, input logic wreg,
                        input int g, input int r, input logic [31:0] rword);
    bit memop = op_size(op) != 0;
    bit ld = is_load(op);
    bit trap = TRAP_EN && memop && misaligned(op, addr);
    int exp_stall;
    int stalls = 0;
    int xfers = 0;
    bit done = 0;
    bit exp_req;
    logic [31:0] exp_res;
    aluop_i = op; mem_addr_i = addr; reg2_i = rs2; wdata_i = wdat; wd_i = wd; wreg_i = wreg;
    if (!memop) exp_stall = 0;
    else if (trap) exp_stall = 1;
    else if (!ld) exp_stall = g + 1;
    else exp_stall = g + 1 + r;
    exp_res = trap ? 32'd0 : (ld ? model_load(op, addr, rword) : wdat);
    exp_q.push_back(exp_res);
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      dbus_gnt_i = (cyc == g);
      dbus_rvalid_i = 1'b0;
      dbus_rdata_i = $urandom;
      if (cyc < g) dbus_rvalid_i = 1'($urandom_range(0, 1));
      else if (ld && cyc > g && cyc < g + r) dbus_gnt_i = 1'($urandom_range(0, 1));
      else if (ld && cyc == g + r) begin
        dbus_rvalid_i = 1'b1;
        dbus_rdata_i = rword;
      end
      @(negedge clk);
      exp_req = memop && !trap && cyc <= g;
      check("req", dbus_req_o, exp_req);
      if (exp_req) begin
        check("addr", dbus_addr_o, addr & 32'hFFFFFFFC);
        check("be", dbus_be_o, model_be(op, addr));
        check("we", dbus_we_o, !ld);
        if (!ld) check("st_wdata", dbus_wdata_o, model_wdata(op, rs2));
      end
      if (dbus_req_o && dbus_gnt_i) xfers++;
      if (stallreq_o) stalls++;
      else begin
        done = 1;
        check("wdata_o", wdata_o, exp_q.pop_front());
        check("wreg_o", wreg_o, trap ? 1'b0 : wreg);
        check("wd_o", wd_o, wd);
        check("misalign_o", misalign_o, trap);
      end
      @(posedge clk); #1;
    end
    if (!done) check("timeout", 32'd0, 32'd1);
    check("stall_cycles", stalls, exp_stall);
    check("xfers", xfers, (memop && !trap) ? 1 : 0);
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; aluop_i = OP_NOP;
  endtask

  localparam logic [7:0] OPS [10] = '{OP_NOP, OP_ADD, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
                                      OP_SB, OP_SH, OP_SW};

  initial begin
    rst = 1'b1; aluop_i = OP_NOP; mem_addr_i = '0; reg2_i = '0; wdata_i = '0; wd_i = '0;
    wreg_i = 1'b0; dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = '0;
    repeat (2) @(negedge clk);
    check("rst_req", dbus_req_o, 1'b0);
    check("rst_stall", stallreq_o, 1'b0);
    check("rst_state", dbg_state_o, 2'd0);
    check("rst_wdata", wdata_o, 32'd0);
    check("rst_misalign", misalign_o, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(OP_SW, 32'h100, 32'hDEADBEEF, 32'h0, 5'd0, 1'b0, 0, 0, 32'h0);
    run_op(OP_LB, 32'h103, 32'h0, 32'h0, 5'd3, 1'b1, 0, 2, 32'h80FFFF7F);
    run_op(OP_LHU, 32'h102, 32'h0, 32'h0, 5'd4, 1'b1, 1, 1, 32'h80011234);
    run_op(OP_SH, 32'h102, 32'h0000ABCD, 32'h0, 5'd0, 1'b0, 0, 0, 32'h0);
    run_op(OP_SB, 32'h201, 32'h000000A5, 32'h0, 5'd0, 1'b0, 3, 0, 32'h0);
    run_op(OP_LW, 32'h102, 32'h0, 32'h0, 5'd7, 1'b1, 0, 1, 32'h11223344);
    run_op(OP_ADD, 32'h0, 32'h0, 32'h12345678, 5'd9, 1'b1, 0, 0, 32'h0);

    // reset while waiting for load data; the late rvalid must be dropped
    aluop_i = OP_LW; mem_addr_i = 32'h100; wd_i = 5'd5; wreg_i = 1'b1; dbus_gnt_i = 1'b1;
    @(posedge clk); #1;
    dbus_gnt_i = 1'b0;
    @(negedge clk);
    check("wait_stall", stallreq_o, 1'b1);
    #2;
    rst = 1'b1; aluop_i = OP_NOP;
    #1;
    check("mid_rst_state", dbg_state_o, 2'd0);
    check("mid_rst_stall", stallreq_o, 1'b0);
    check("mid_rst_req", dbus_req_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'hCAFEF00D;
    @(negedge clk);
    check("late_rvalid_state", dbg_state_o, 2'd0);
    @(posedge clk); #1;
    dbus_rvalid_i = 1'b0; aluop_i = OP_LW; mem_addr_i = 32'h100;
    #1;
    check("late_rvalid_capture", wdata_o, 32'd0);
    run_op(OP_LW, 32'h100, 32'h0, 32'h0, 5'd5, 1'b1, 2, 3, 32'h55AA00FF);

    for (int i = 0; i < 200; i++) begin
      logic [7:0] op;
      op = OPS[$urandom_range(0, 9)];
      run_op(op, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
             (op_size(op) != 0 && !is_load(op)) ? 1'b0 : 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), $urandom_range(1, 3), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
